// File: rtl/outport_credit_arb_if.sv
// Bundle of request, grant and credit-status signals between the input
// ports / downstream link (master side) and one output-port allocator
// (slave side).
interface outport_credit_arb_if #(
    parameter int P  = 7,
    parameter int B  = 4,
    parameter int PW = $clog2(P),
    parameter int CW = $clog2(B + 1)
);
    logic [P-1:0]  req;
    logic [P-1:0]  req_tail;
    logic          credit_in;
    logic [P-1:0]  grant;
    logic          flit_out_wr;
    logic          outport_available;
    logic [PW-1:0] owner;
    logic [CW-1:0] credit_cnt;
    logic          credit_err;

    modport master (
        output req, req_tail, credit_in,
        input  grant, flit_out_wr, outport_available, owner, credit_cnt, credit_err
    );

    modport slave (
        input  req, req_tail, credit_in,
        output grant, flit_out_wr, outport_available, owner, credit_cnt, credit_err
    );
endinterface

// File: rtl/outport_credit_arb.sv
// Output-port allocator: round-robin arbitration among P inputs, packet lock
// from head to tail, and downstream credit tracking.
// Optional macro OUTARB_LOCAL_PRIO_EN: input 0 gets strict priority in IDLE and
// round-robin then covers inputs 1..P-1 only.
module outport_credit_arb #(
    parameter int P  = 7,
    parameter int B  = 4,
    parameter int PW = $clog2(P),
    parameter int CW = $clog2(B + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    outport_credit_arb_if.slave  bus
);
`ifdef OUTARB_LOCAL_PRIO_EN
    localparam bit LOCAL_PRIO = 1'b1;
`else
    localparam bit LOCAL_PRIO = 1'b0;
`endif

    typedef enum logic {IDLE, LOCKED} state_t;

    state_t        state;
    logic [PW-1:0] rr_ptr;
    logic [PW-1:0] owner_q;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_nxt;
    logic          err_q;
    logic          avail_q;

    logic          has_credit;
    logic [PW-1:0] win;
    logic          win_vld;
    logic [P-1:0]  grant_c;
    logic          wr;
    logic          tail_win;
    logic          tail_own;
    logic          overflow;
    logic          next_idle;

    // Increment an input index with wrap from P-1 back to 0.
    function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] i);
        if (int'(i) == P - 1) return '0;
        return i + PW'(1);
    endfunction

    assign has_credit = (cnt_q != '0);

    // Pick the IDLE-state winner: optional local-port priority, else the first
    // requester at or after rr_ptr (input 0 skipped when it has priority).
    always_comb begin
        int idx;
        idx     = 0;
        win     = '0;
        win_vld = 1'b0;
        if (LOCAL_PRIO && bus.req[0]) begin
            win_vld = 1'b1;
        end
        for (int k = 0; k < P; k++) begin
            idx = int'(rr_ptr) + k;
            if (idx >= P) idx = idx - P;
            if (!win_vld && !(LOCAL_PRIO && idx == 0) && bus.req[PW'(idx)]) begin
                win     = PW'(idx);
                win_vld = 1'b1;
            end
        end
    end

    // Same-cycle grant: winner in IDLE, owner only while LOCKED, never without credit.
    always_comb begin
        grant_c = '0;
        if (!rst && has_credit) begin
            if (state == IDLE) begin
                if (win_vld) grant_c[win] = 1'b1;
            end else begin
                grant_c[owner_q] = bus.req[owner_q];
            end
        end
    end

    assign wr       = |grant_c;
    assign tail_win = bus.req_tail[win];
    assign tail_own = bus.req_tail[owner_q];
    assign overflow = !wr && bus.credit_in && (cnt_q == CW'(B));

    // Next-cycle credit count and lock status feed the registered availability flag.
    always_comb begin
        cnt_nxt = cnt_q;
        if (wr && !bus.credit_in) begin
            cnt_nxt = cnt_q - CW'(1);
        end else if (!wr && bus.credit_in && !overflow) begin
            cnt_nxt = cnt_q + CW'(1);
        end
        next_idle = (state == IDLE) ? !(wr && !tail_win) : (wr && tail_own);
    end

    // Lock FSM: head flits lock the port to the winner, the tail releases it and
    // advances the round-robin pointer past the finished input.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            rr_ptr  <= '0;
            owner_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (wr) begin
                        if (tail_win) begin
                            if (!(LOCAL_PRIO && win == '0)) rr_ptr <= wrap_inc(win);
                        end else begin
                            state   <= LOCKED;
                            owner_q <= win;
                        end
                    end
                end
                LOCKED: begin
                    if (wr && tail_own) begin
                        state   <= IDLE;
                        owner_q <= '0;
                        if (!(LOCAL_PRIO && owner_q == '0)) rr_ptr <= wrap_inc(owner_q);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Credit counter with saturation at B, sticky overflow flag, and availability.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q   <= CW'(B);
            err_q   <= 1'b0;
            avail_q <= 1'b1;
        end else begin
            cnt_q   <= cnt_nxt;
            err_q   <= err_q | overflow;
            avail_q <= (cnt_nxt != '0) && next_idle;
        end
    end

    assign bus.grant             = grant_c;
    assign bus.flit_out_wr       = wr;
    assign bus.outport_available = avail_q;
    assign bus.owner             = owner_q;
    assign bus.credit_cnt        = cnt_q;
    assign bus.credit_err        = err_q;
endmodule

// File: tb/tb_outport_credit_arb.sv
// Bench for outport_credit_arb: a packet-level model of the allocator checks
// every cycle, directed sequences pin the model with literal values, then a
// randomized run exercises arbitration, locking, credits and resets.
module tb_outport_credit_arb;
    localparam int P  = 7;
    localparam int B  = 4;
    localparam int PW = $clog2(P);
    localparam int CW = $clog2(B + 1);
`ifdef OUTARB_LOCAL_PRIO_EN
    localparam bit LP = 1'b1;
`else
    localparam bit LP = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    outport_credit_arb_if #(.P(P), .B(B)) bus ();

    outport_credit_arb #(.P(P), .B(B)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_chk = 0;
    int n_err = 0;

    // Model state: packet lock, owner, round-robin start, credits, overflow flag.
    bit m_valid  = 1'b0;
    bit m_locked = 1'b0;
    int m_owner  = 0;
    int m_rr     = 0;
    int m_cred   = B;
    bit m_err    = 1'b0;

    logic [P-1:0] m_g;
    int           m_w;

    function automatic logic [P-1:0] exp_grant();
        logic [P-1:0] g;
        g = '0;
        if (rst || m_cred == 0) return g;
        if (m_locked) begin
            if (bus.req[m_owner]) g[m_owner] = 1'b1;
            return g;
        end
        if (LP && bus.req[0]) begin
            g[0] = 1'b1;
            return g;
        end
        for (int k = 0; k < P; k++) begin
            int i;
            i = (m_rr + k) % P;
            if (!(LP && i == 0) && bus.req[i]) begin
                g[i] = 1'b1;
                return g;
            end
        end
        return g;
    endfunction

    function automatic int onehot_idx(input logic [P-1:0] g);
        for (int i = 0; i < P; i++) if (g[i]) return i;
        return 0;
    endfunction

    always_comb begin
        m_g = exp_grant();
        m_w = onehot_idx(m_g);
    end

    // Advance the model once per clock from the inputs the bench applied.
    always @(posedge clk) begin
        if (rst) begin
            m_valid  <= 1'b1;
            m_locked <= 1'b0;
            m_owner  <= 0;
            m_rr     <= 0;
            m_cred   <= B;
            m_err    <= 1'b0;
        end else begin
            if (m_g != '0) begin
                if (!m_locked) begin
                    if (bus.req_tail[m_w]) begin
                        if (!(LP && m_w == 0)) m_rr <= (m_w + 1) % P;
                    end else begin
                        m_locked <= 1'b1;
                        m_owner  <= m_w;
                    end
                end else if (bus.req_tail[m_owner]) begin
                    m_locked <= 1'b0;
                    m_owner  <= 0;
                    if (!(LP && m_owner == 0)) m_rr <= (m_owner + 1) % P;
                end
            end
            if (m_g != '0 && !bus.credit_in) begin
                m_cred <= m_cred - 1;
            end else if (m_g == '0 && bus.credit_in) begin
                if (m_cred == B) m_err <= 1'b1;
                else m_cred <= m_cred + 1;
            end
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Apply one cycle of inputs and compare every output with the model.
    task automatic step(input logic r, input logic [P-1:0] rq, input logic [P-1:0] tl,
                        input logic ci);
        @(negedge clk);
        rst           = r;
        bus.req       = rq;
        bus.req_tail  = tl;
        bus.credit_in = ci;
        #1;
        if (m_valid) begin
            chk("grant", int'(bus.grant), int'(m_g));
            chk("flit_out_wr", int'(bus.flit_out_wr), int'(m_g != '0));
            chk("owner", int'(bus.owner), m_owner);
            chk("credit_cnt", int'(bus.credit_cnt), m_cred);
            chk("outport_available", int'(bus.outport_available),
                int'(m_cred != 0 && !m_locked));
            chk("credit_err", int'(bus.credit_err), int'(m_err));
        end
    endtask

    initial begin
        bus.req       = '0;
        bus.req_tail  = '0;
        bus.credit_in = 1'b0;

        // Reset state.
        step(1, '0, '0, 0);
        step(1, 7'b0000110, '0, 0);
        chk("lit_rst_grant", int'(bus.grant), 0);
        step(0, '0, '0, 0);
        chk("lit_rst_cnt", int'(bus.credit_cnt), 4);
        chk("lit_rst_avail", int'(bus.outport_available), 1);
        chk("lit_rst_owner", int'(bus.owner), 0);

        // Two single-flit packets from inputs 1 and 2.
        step(0, 7'b0000110, 7'b0000110, 0);
        chk("lit_rr_g0", int'(bus.grant), 7'b0000010);
        step(0, 7'b0000110, 7'b0000110, 0);
        chk("lit_rr_g1", int'(bus.grant), 7'b0000100);
        chk("lit_rr_cnt1", int'(bus.credit_cnt), 3);
        step(0, '0, '0, 0);
        chk("lit_rr_cnt2", int'(bus.credit_cnt), 2);

        // Three-flit packet from input 3 blocks input 5.
        step(1, '0, '0, 0);
        step(0, 7'b0101000, 7'b0000000, 0);
        chk("lit_lock_g0", int'(bus.grant), 7'b0001000);
        step(0, 7'b0101000, 7'b0000000, 0);
        chk("lit_lock_g1", int'(bus.grant), 7'b0001000);
        chk("lit_lock_owner", int'(bus.owner), 3);
        step(0, 7'b0101000, 7'b0001000, 0);
        chk("lit_lock_g2", int'(bus.grant), 7'b0001000);
        step(0, 7'b0100000, 7'b0100000, 0);
        chk("lit_lock_g3", int'(bus.grant), 7'b0100000);

        // Credit exhaustion and one returned credit.
        step(1, '0, '0, 0);
        for (int k = 0; k < 6; k++) begin
            step(0, 7'b0000010, 7'b0000010, 0);
            chk("lit_cred_grant", int'(bus.grant), (k < 4) ? 2 : 0);
        end
        step(0, 7'b0000010, 7'b0000010, 1);
        chk("lit_cred_zero", int'(bus.credit_cnt), 0);
        chk("lit_cred_avail", int'(bus.outport_available), 0);
        step(0, 7'b0000010, 7'b0000010, 0);
        chk("lit_cred_one_more", int'(bus.grant), 7'b0000010);
        step(0, 7'b0000010, 7'b0000010, 0);
        chk("lit_cred_none", int'(bus.grant), 0);

        // Simultaneous credit and flit, then overflow.
        step(1, '0, '0, 0);
        step(0, 7'b0000010, 7'b0000010, 0);
        step(0, 7'b0000010, 7'b0000010, 0);
        step(0, 7'b0000010, 7'b0000010, 1);
        chk("lit_both_cnt_before", int'(bus.credit_cnt), 2);
        step(0, '0, '0, 1);
        chk("lit_both_cnt_after", int'(bus.credit_cnt), 2);
        step(0, '0, '0, 1);
        step(0, '0, '0, 1);
        chk("lit_ovf_cnt_full", int'(bus.credit_cnt), 4);
        chk("lit_ovf_err_before", int'(bus.credit_err), 0);
        step(0, '0, '0, 0);
        chk("lit_ovf_cnt_sat", int'(bus.credit_cnt), 4);
        chk("lit_ovf_err", int'(bus.credit_err), 1);
        step(0, '0, '0, 0);
        chk("lit_ovf_err_sticky", int'(bus.credit_err), 1);

        // Reset while locked mid-packet.
        step(1, '0, '0, 0);
        step(0, 7'b0000100, 7'b0000000, 0);
        step(0, '0, '0, 0);
        chk("lit_midrst_owner", int'(bus.owner), 2);
        step(1, 7'b0000100, '0, 0);
        chk("lit_midrst_grant", int'(bus.grant), 0);
        step(0, 7'b0010000, 7'b0010000, 0);
        chk("lit_midrst_owner0", int'(bus.owner), 0);
        chk("lit_midrst_cnt", int'(bus.credit_cnt), 4);
        chk("lit_midrst_new", int'(bus.grant), 7'b0010000);

`ifdef OUTARB_LOCAL_PRIO_EN
        // Local port priority leaves the round-robin pointer at 3.
        step(1, '0, '0, 0);
        step(0, 7'b0000100, 7'b0000100, 0);
        step(0, 7'b0001001, 7'b0001001, 0);
        chk("lit_prio_g0", int'(bus.grant), 7'b0000001);
        step(0, 7'b0001010, 7'b0001010, 0);
        chk("lit_prio_g1", int'(bus.grant), 7'b0001000);
`endif

        // Randomized traffic, credits and occasional resets.
        step(1, '0, '0, 0);
        for (int n = 0; n < 3000; n++) begin
            step(($urandom_range(0, 199) == 0),
                 P'($urandom),
                 P'($urandom) | P'($urandom),
                 ($urandom_range(0, 2) == 0));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/outport_credit_arb.md
Name: outport_credit_arb

Overview:
- Per-output-port allocation controller for the NoC router: one instance per output port, alongside the crossbar.
- Arbitrates round-robin among P input ports requesting this output.
- Locks the output to the winner until that packet's tail flit has passed.
- Tracks downstream buffer credits, so a flit is granted only when a slot is free. Drives the crossbar select column and the output write strobe.

Parameters:
- P, 7, number of input ports requesting this output (2..16).
- B, 4, downstream buffer depth; initial and maximum credit count (1..15).
- PW, $clog2(P), width of owner index.
- CW, $clog2(B+1), width of credit counter.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous, active-high reset.
- req  input  P  req[i]=1: input i presents a flit routed to this output this cycle.
- req_tail  input  P  req_tail[i]=1: the flit presented by input i is a tail (single-flit packet = head+tail); ignored when req[i]=0.
- credit_in  input  1  downstream freed one buffer slot (one pulse per slot).
- grant  output  P  one-hot or zero, combinational; grant[i]=1 means input i's flit transfers this cycle.
- flit_out_wr  output  1  equals |grant; output register write strobe.
- outport_available  output  1  registered; 1 when credit_cnt!=0 and state==IDLE.
- owner  output  PW  registered; index of the locked input, 0 when IDLE.
- credit_cnt  output  CW  registered credit count.
- credit_err  output  1  sticky; credit overflow detected.

Behaviour:
Reset (rst=1 at a clk edge):
- state=IDLE, rr_ptr=0, owner=0, credit_cnt=B, credit_err=0.
- Regardless of req: grant=0, flit_out_wr=0.
- Reset asserted mid-packet discards the lock with no tail required. Credits return to B, so the system reset must also flush the downstream buffer.

States: IDLE, LOCKED.

IDLE:
- If credit_cnt!=0 and req!=0, grant the first requester at or after rr_ptr, scanning upward with wrap P-1 to 0.
- Winner w with req_tail[w]=1: stay IDLE; rr_ptr <= (w+1) mod P.
- Winner w with req_tail[w]=0: go to LOCKED; owner<=w; rr_ptr unchanged.
- If credit_cnt==0 or req==0: grant=0, no state change.

LOCKED:
- grant[owner]=req[owner] && credit_cnt!=0. All other inputs are blocked even when credits are available.
- Granted flit with req_tail[owner]=1: go to IDLE next cycle; rr_ptr <= (owner+1) mod P; owner<=0.
- A gap in req[owner] keeps the lock indefinitely.

Credit counter:
- Decrement on flit_out_wr; increment on credit_in.
- Both in the same cycle: unchanged.
- credit_in with credit_cnt==B and no flit_out_wr: count saturates at B and credit_err<=1 (sticky until rst).
- credit_cnt never goes below 0, because grant is already gated by credit_cnt!=0.

Latency and timing:
- Grant is same-cycle combinational from req, state and credit_cnt.
- Zero-cycle turnaround: in IDLE a new packet may be granted in the cycle after a tail.
- Back-to-back single-flit packets from different inputs are granted on consecutive cycles.
- Throughput: 1 flit/cycle while credits last. With B credits and a credit round-trip R, sustained rate is min(1, B/R).

Optional Feature:
- Macro: OUTARB_LOCAL_PRIO_EN.
- Defined: input 0 (local port) has strict priority in IDLE. If req[0]=1 and credit_cnt!=0, input 0 wins regardless of rr_ptr, and rr_ptr is not updated by input-0 packets. Round-robin applies only among inputs 1..P-1. LOCKED behaviour is unchanged.
- Undefined: pure round-robin over all P inputs as described above.

Test Plan:
- Reset then req=7'b0000110, all tails → cycle0 grant=0000010, cycle1 grant=0000100, rr_ptr=3. credit_cnt goes 4→3→2 with no credit_in.
- Input 3 sends a 3-flit packet (tail on the 3rd flit) while req[5]=1 continuously → grant=0001000 for 3 cycles, owner=3, grant[5]=0 throughout; grant=0100000 in the 4th cycle.
- B=4, no credit_in, input 1 requests 6 single flits → 4 grants, then credit_cnt=0, grant=0, outport_available=0. One credit_in pulse → exactly one further grant.
- credit_in and a granted flit in the same cycle with credit_cnt=2 → credit_cnt stays 2. credit_in at credit_cnt=4 (B) with no grant → credit_cnt=4, credit_err=1 and stays 1.
- LOCKED on owner=2 after a head flit, rst=1 for one cycle → next cycle state IDLE, owner=0, credit_cnt=4, grant=0. req[4]=1 tail after rst → grant=0010000.
- OUTARB_LOCAL_PRIO_EN defined, rr_ptr=3, req=7'b0001001, all tails → grant=0000001 then 0001000; rr_ptr stays 3 after the input-0 grant.
